clk_mode_ctrl: RTL
==================

// Module: clk_mode_ctrl
// PURPOSE
//  Synchronous mode/setup controller for the HH:MM:SS digital clock.
//  - Debounces the three push-buttons and runs the CLOCK/SET mode FSM.
//  - Emits single-cycle count enables for the sec/min/hour counters; no derived or gated clocks.
//  - Sits between the board switches and the hms counter bank; also drives field-blink flags for the display.
// PARAMETERS
//  SEC_DIV   50_000_000  clk cycles per 1 s tick (>=4, even)
//  DB_DIV    500_000     clk cycles per debounce sample (10 ms)
//  RPT_DLY   50          debounce samples held before auto-repeat starts
//  RPT_RATE  10          debounce samples between auto-repeat pulses
// PORTS
//  clk           in   1  system clock
//  rst_n         in   1  asynchronous active-low reset
//  i_sw0         in   1  mode button, async, active-low (0 = pressed)
//  i_sw1         in   1  field-select button, async, active-low
//  i_sw2         in   1  increment button, async, active-low
//  i_sec_at_max  in   1  level: seconds counter == 59
//  i_min_at_max  in   1  level: minutes counter == 59
//  o_state       out  2  00 CLOCK, 01 SET_SEC, 10 SET_MIN, 11 SET_HOUR
//  o_sec_en      out  1  1-cycle increment enable, seconds counter
//  o_min_en      out  1  1-cycle increment enable, minutes counter
//  o_hour_en     out  1  1-cycle increment enable, hours counter
//  o_blink       out  3  {hour,min,sec} blank-field flags for display
// BEHAVIOUR
//  Reset is asynchronous, active-low on rst_n; clock is clk. On reset: o_state=CLOCK, all enables and o_blink=0,
//   prescaler=0, debounced levels=released(1), repeat counters=0.
//  Buttons: 2-FF sync on clk; sample every DB_DIV cycles; debounced level changes after 2 equal consecutive
//   samples. press = 1-cycle pulse on debounced 1->0. Latency pin fall -> press <= 2+2*DB_DIV cycles.
//  Auto-repeat (sw2 only): while debounced low, after RPT_DLY samples, one repeat pulse every RPT_RATE samples.
//   Release clears repeat counter immediately.
//  FSM: sw0 press: CLOCK->SET_SEC; any SET_*->CLOCK. sw1 press in SET: SEC->MIN->HOUR->SEC; ignored in CLOCK.
//   sw0 and sw1 press in same cycle: sw0 wins, sw1 dropped.
//  Prescaler: counts 0..SEC_DIV-1 and wraps; tick = (cnt==SEC_DIV-1). Forced to 0 on the cycle the FSM enters
//   CLOCK, so the first tick after leaving setup comes exactly SEC_DIV cycles later.
//  CLOCK: o_sec_en=tick; o_min_en=tick&i_sec_at_max; o_hour_en=tick&i_sec_at_max&i_min_at_max.
//   sw2 ignored. o_blink=000.
//  SET_x: tick suppressed. inc = sw2 press | repeat pulse; drives only the selected field's enable; no carry.
//   inc in the same cycle as a state change is dropped.
//   o_blink: only the selected field bit may be 1; it equals (cnt < SEC_DIV/2), giving 1 Hz, 50 % duty.
//  All outputs are registered: one cycle after the causing event, never high more than 1 cycle per event.
//  Width: prescaler $clog2(SEC_DIV) bits; sample counter $clog2(DB_DIV) bits; repeat counter
//   $clog2(RPT_DLY+1) bits; no overflow permitted at any parameter legal value.
// STRUCTURE
//  Package clk_pkg: state encodings ST_CLOCK/ST_SET_SEC/ST_SET_MIN/ST_SET_HOUR; BTN_PRESSED=1'b0.
//  Sub-module sw_debounce (sync, sampler, press pulse, optional repeat via parameter RPT_EN):
//   - instanced 3x with a shared sample strobe generated once in clk_mode_ctrl.
//  Top level holds the FSM, prescaler, enable mux and blink logic.
// TESTING (SEC_DIV=10, DB_DIV=2, RPT_DLY=4, RPT_RATE=2)
//  Release reset, idle 35 cycles -> o_sec_en 1-cycle pulses at cycles 10,20,30; min/hour_en stay 0.
//  Hold i_sec_at_max=1, i_min_at_max=0, then both 1 -> o_min_en coincides with each o_sec_en; then all three pulse together.
//  Hold sw0 low 12 cycles -> o_state=01 within 6 cycles; no o_sec_en; o_blink=001/000 alternating every 5 cycles.
//  SET_MIN, sw2 low 6 cycles then high -> exactly one o_min_en, zero o_sec_en/o_hour_en.
//  SET_HOUR, hold sw2 40 cycles -> press pulse, then repeat pulses every 4 cycles after 8-cycle delay; stop on release.
//  SET_SEC, sw0+sw1 pressed together -> CLOCK, position not advanced.
//   First o_sec_en exactly 10 cycles after entering CLOCK; rst_n low mid-hold -> all outputs 0 at once.

Source files
------------

// File: rtl/clk_pkg.sv
// Shared encodings for the HH:MM:SS clock mode/setup controller.
package clk_pkg;

  typedef enum logic [1:0] {
    ST_CLOCK    = 2'b00,
    ST_SET_SEC  = 2'b01,
    ST_SET_MIN  = 2'b10,
    ST_SET_HOUR = 2'b11
  } state_t;

  localparam logic BTN_PRESSED = 1'b0;

  // One-hot {hour,min,sec} flag of the field being edited; zero in CLOCK.
  function automatic logic [2:0] field_mask(input state_t st);
    case (st)
      ST_SET_SEC:  field_mask = 3'b001;
      ST_SET_MIN:  field_mask = 3'b010;
      ST_SET_HOUR: field_mask = 3'b100;
      default:     field_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Push-button conditioner: 2-FF synchronizer, strobed two-sample debounce,
// press pulse on debounced 1->0 and optional hold-to-repeat pulses.
module sw_debounce
  import clk_pkg::*;
#(
  parameter int RPT_EN   = 0,
  parameter int RPT_DLY  = 50,
  parameter int RPT_RATE = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  input  logic strobe,
  output logic pulse
);

  localparam int RW = $clog2(RPT_DLY + 1);
  localparam logic [RW-1:0] RPT_TOP    = RW'(RPT_DLY - 1);
  // Reloading below the top makes later pulses RPT_RATE samples apart
  // without a second counter (RPT_RATE must not exceed RPT_DLY).
  localparam logic [RW-1:0] RPT_RELOAD = RW'(RPT_DLY - RPT_RATE);

  logic          sync1, sync2, samp, level;
  logic [RW-1:0] rpt_cnt;
  logic          fall, rise, rpt;

  assign fall  = strobe && (samp == sync2) && (sync2 == BTN_PRESSED) && (level != BTN_PRESSED);
  assign rise  = strobe && (samp == sync2) && (sync2 != BTN_PRESSED) && (level == BTN_PRESSED);
  assign rpt   = (RPT_EN != 0) && strobe && (level == BTN_PRESSED) && !rise && (rpt_cnt == RPT_TOP);
  assign pulse = fall | rpt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      samp    <= 1'b1;
      level   <= 1'b1;
      rpt_cnt <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      if (strobe) begin
        samp <= sync2;
        if (samp == sync2) level <= sync2;
      end
      if ((RPT_EN == 0) || (level != BTN_PRESSED) || rise)
        rpt_cnt <= '0;
      else if (strobe)
        rpt_cnt <= (rpt_cnt == RPT_TOP) ? RPT_RELOAD : rpt_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clk_mode_ctrl.sv
// CLOCK/SET mode controller: debounced buttons, 1 s prescaler, single-cycle
// count enables for the hms counters and field-blink flags for the display.
module clk_mode_ctrl
  import clk_pkg::*;
#(
  parameter int SEC_DIV  = 50_000_000,
  parameter int DB_DIV   = 500_000,
  parameter int RPT_DLY  = 50,
  parameter int RPT_RATE = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw0,
  input  logic       i_sw1,
  input  logic       i_sw2,
  input  logic       i_sec_at_max,
  input  logic       i_min_at_max,
  output logic [1:0] o_state,
  output logic       o_sec_en,
  output logic       o_min_en,
  output logic       o_hour_en,
  output logic [2:0] o_blink
);

  localparam int PW = $clog2(SEC_DIV);
  localparam int DW = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;
  localparam logic [PW-1:0] PS_MAX  = PW'(SEC_DIV - 1);
  localparam logic [PW-1:0] PS_HALF = PW'(SEC_DIV / 2);
  localparam logic [DW-1:0] DB_MAX  = DW'(DB_DIV - 1);

  logic [DW-1:0] db_cnt;
  logic          strobe;
  logic          mode_p, sel_p, inc;

  assign strobe = (db_cnt == DB_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) db_cnt <= '0;
    else        db_cnt <= strobe ? '0 : db_cnt + 1'b1;
  end

  sw_debounce #(.RPT_EN(0), .RPT_DLY(RPT_DLY), .RPT_RATE(RPT_RATE)) u_sw0 (
    .clk(clk), .rst_n(rst_n), .pin(i_sw0), .strobe(strobe), .pulse(mode_p)
  );
  sw_debounce #(.RPT_EN(0), .RPT_DLY(RPT_DLY), .RPT_RATE(RPT_RATE)) u_sw1 (
    .clk(clk), .rst_n(rst_n), .pin(i_sw1), .strobe(strobe), .pulse(sel_p)
  );
  sw_debounce #(.RPT_EN(1), .RPT_DLY(RPT_DLY), .RPT_RATE(RPT_RATE)) u_sw2 (
    .clk(clk), .rst_n(rst_n), .pin(i_sw2), .strobe(strobe), .pulse(inc)
  );

  state_t        st, st_next;
  logic [PW-1:0] ps_cnt;
  logic          tick, enter_clock, set_inc;

  // Mode wins over field-select when both presses land in the same cycle.
  always_comb begin
    st_next = st;
    if (mode_p) begin
      st_next = (st == ST_CLOCK) ? ST_SET_SEC : ST_CLOCK;
    end else if (sel_p) begin
      case (st)
        ST_SET_SEC:  st_next = ST_SET_MIN;
        ST_SET_MIN:  st_next = ST_SET_HOUR;
        ST_SET_HOUR: st_next = ST_SET_SEC;
        default:     st_next = st;
      endcase
    end
  end

  assign tick        = (ps_cnt == PS_MAX);
  assign enter_clock = (st != ST_CLOCK) && (st_next == ST_CLOCK);
  assign set_inc     = inc && (st != ST_CLOCK) && (st_next == st);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_CLOCK;
      ps_cnt    <= '0;
      o_sec_en  <= 1'b0;
      o_min_en  <= 1'b0;
      o_hour_en <= 1'b0;
      o_blink   <= 3'b000;
    end else begin
      st     <= st_next;
      ps_cnt <= (enter_clock || tick) ? '0 : ps_cnt + 1'b1;
      if (st == ST_CLOCK) begin
        o_sec_en  <= tick;
        o_min_en  <= tick && i_sec_at_max;
        o_hour_en <= tick && i_sec_at_max && i_min_at_max;
      end else begin
        o_sec_en  <= set_inc && (st == ST_SET_SEC);
        o_min_en  <= set_inc && (st == ST_SET_MIN);
        o_hour_en <= set_inc && (st == ST_SET_HOUR);
      end
      // Blink follows the incoming state so it never flags a field being left.
      o_blink <= (ps_cnt < PS_HALF) ? field_mask(st_next) : 3'b000;
    end
  end

  assign o_state = st;

endmodule
